// File: rtl/counter_down_pkg.sv
// counter_down_pkg: shared state encoding for the down counter
package counter_down_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_t;
endpackage

// File: rtl/counter_down_core.sv
// counter_down_core: count and reload registers with decrement/reload mux and zero detect
module counter_down_core #(
    parameter int DATA_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] dload,
    input  logic                  dec,
    input  logic                  reload_now,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  zero
);
    logic [DATA_WIDTH-1:0] reload;
    logic [DATA_WIDTH-1:0] q_next;

    assign q_next = load ? dload : reload_now ? reload : dec ? q - 1'b1 : q;
    assign zero   = (q == '0);

    // count register follows the mux; reload register captures each load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= CLEAR_VAL;
            reload <= CLEAR_VAL;
        end else begin
            q <= q_next;
            if (load) reload <= dload;
        end
    end
endmodule

// File: rtl/counter_down.sv
// counter_down: loadable down counter with one-shot/periodic modes and underflow flags
module counter_down
    import counter_down_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int CLEAR_VAL  = 0
) (
    input  logic                  C,
    input  logic                  CLR,
    input  logic [DATA_WIDTH-1:0] DLOAD,
    input  logic                  LOAD,
    input  logic                  EN,
    input  logic                  PERIODIC,
    input  logic                  ACK,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] notQ,
    output logic                  zero,
    output logic                  underflow,
    output logic                  sticky_uf,
    output logic [STATE_W-1:0]    state
);
    localparam logic [DATA_WIDTH-1:0] CV = DATA_WIDTH'(CLEAR_VAL);

    state_t st, st_next;
    logic   periodic;
    logic   dec;
    logic   terminal;

    counter_down_core #(.DATA_WIDTH(DATA_WIDTH), .CLEAR_VAL(CV)) core (
        .clk        (C),
        .rst        (CLR),
        .load       (LOAD),
        .dload      (DLOAD),
        .dec        (dec),
        .reload_now (terminal & periodic),
        .q          (Q),
        .zero       (zero)
    );

    assign notQ  = ~Q;
    assign state = st;

    // state, mode latch and flags; a terminal event beats a coincident ACK
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            st        <= ST_IDLE;
            periodic  <= 1'b0;
            underflow <= 1'b0;
            sticky_uf <= 1'b0;
        end else begin
            st        <= st_next;
            underflow <= terminal;
            sticky_uf <= terminal ? 1'b1 : ACK ? 1'b0 : sticky_uf;
            if (LOAD) periodic <= PERIODIC;
        end
    end

    // next state plus decrement/terminal strobes; LOAD overrides everything
    always_comb begin
        st_next  = st;
        dec      = 1'b0;
        terminal = 1'b0;
        if (LOAD) begin
            st_next = (DLOAD == '0) ? ST_DONE : ST_RUN;
        end else begin
            case (st)
                ST_IDLE: st_next = ST_IDLE;
                ST_RUN: begin
                    dec      = EN & ~zero;
                    terminal = EN & zero;
                    st_next  = (terminal && !periodic) ? ST_DONE : ST_RUN;
                end
                ST_DONE: st_next = ACK ? ST_IDLE : ST_DONE;
                default: st_next = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_counter_down.sv
// tb_counter_down: directed self-checking bench for counter_down
module tb_counter_down;
    logic       C = 1'b0;
    logic       CLR = 1'b0;
    logic [3:0] DLOAD = '0;
    logic       LOAD = 1'b0;
    logic       EN = 1'b0;
    logic       PERIODIC = 1'b0;
    logic       ACK = 1'b0;
    logic [3:0] Q;
    logic [3:0] notQ;
    logic       zero;
    logic       underflow;
    logic       sticky_uf;
    logic [1:0] state;
    int checks = 0;
    int errors = 0;

    counter_down #(.DATA_WIDTH(4), .CLEAR_VAL(5)) dut (
        .C(C), .CLR(CLR), .DLOAD(DLOAD), .LOAD(LOAD), .EN(EN), .PERIODIC(PERIODIC),
        .ACK(ACK), .Q(Q), .notQ(notQ), .zero(zero), .underflow(underflow),
        .sticky_uf(sticky_uf), .state(state)
    );

    always #5 C = ~C;

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        #1 CLR = 1'b1;
        #1;
        checks++; if (Q !== 4'd5) begin errors++; $display("FAIL reset_q got %0d exp 5", Q); end
        checks++; if (notQ !== 4'hA) begin errors++; $display("FAIL reset_notq got %h exp a", notQ); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zero); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if ({underflow, sticky_uf} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {underflow, sticky_uf}); end
        step();
        CLR = 1'b0;
        EN = 1'b1;
        step();
        checks++; if (Q !== 4'd5 || state !== 2'd0) begin errors++; $display("FAIL idle_ignores_en got q=%0d st=%0d exp q=5 st=0", Q, state); end
    endtask

    task automatic test_one_shot();
        logic [3:0] q_exp [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        logic       u_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0] s_exp [5] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        DLOAD = 4'd3; PERIODIC = 1'b0; EN = 1'b1; LOAD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            LOAD = 1'b0;
            checks++; if (Q !== q_exp[i] || underflow !== u_exp[i] || state !== s_exp[i])
                begin errors++; $display("FAIL oneshot[%0d] got q=%0d uf=%b st=%0d exp q=%0d uf=%b st=%0d", i, Q, underflow, state, q_exp[i], u_exp[i], s_exp[i]); end
        end
        checks++; if (sticky_uf !== 1'b1 || zero !== 1'b1) begin errors++; $display("FAIL oneshot_sticky got sticky=%b zero=%b exp 1 1", sticky_uf, zero); end
        step();
        checks++; if (underflow !== 1'b0 || state !== 2'd2 || Q !== 4'd0) begin errors++; $display("FAIL oneshot_done got uf=%b st=%0d q=%0d exp 0 2 0", underflow, state, Q); end
        EN = 1'b0; ACK = 1'b1;
        step();
        ACK = 1'b0;
        checks++; if (state !== 2'd0 || sticky_uf !== 1'b0) begin errors++; $display("FAIL oneshot_ack got st=%0d sticky=%b exp 0 0", state, sticky_uf); end
    endtask

    task automatic test_periodic();
        logic [3:0] q_exp [7] = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
        logic       u_exp [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        DLOAD = 4'd2; PERIODIC = 1'b1; EN = 1'b1; LOAD = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            LOAD = 1'b0;
            checks++; if (Q !== q_exp[i] || underflow !== u_exp[i] || state !== 2'd1)
                begin errors++; $display("FAIL periodic[%0d] got q=%0d uf=%b st=%0d exp q=%0d uf=%b st=1", i, Q, underflow, state, q_exp[i], u_exp[i]); end
        end
        EN = 1'b0; ACK = 1'b1;
        step();
        ACK = 1'b0;
        checks++; if (sticky_uf !== 1'b0 || state !== 2'd1 || Q !== 4'd2) begin errors++; $display("FAIL periodic_ack got sticky=%b st=%0d q=%0d exp 0 1 2", sticky_uf, state, Q); end
    endtask

    task automatic test_en_gaps();
        logic       e_pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] q_exp [5] = '{4'd4, 4'd3, 4'd3, 4'd3, 4'd2};
        DLOAD = 4'd4; PERIODIC = 1'b0; LOAD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            EN = e_pat[i];
            step();
            LOAD = 1'b0;
            checks++; if (Q !== q_exp[i] || underflow !== 1'b0 || notQ !== ~q_exp[i])
                begin errors++; $display("FAIL en_gaps[%0d] got q=%0d notq=%h uf=%b exp q=%0d uf=0", i, Q, notQ, underflow, q_exp[i]); end
        end
    endtask

    task automatic test_priority();
        DLOAD = 4'd2; PERIODIC = 1'b0; EN = 1'b1; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        step();
        checks++; if (Q !== 4'd1) begin errors++; $display("FAIL prio_setup got %0d exp 1", Q); end
        DLOAD = 4'd9; LOAD = 1'b1;
        step();
        checks++; if (Q !== 4'd9 || state !== 2'd1 || underflow !== 1'b0) begin errors++; $display("FAIL prio_load got q=%0d st=%0d uf=%b exp 9 1 0", Q, state, underflow); end
        DLOAD = 4'd0;
        step();
        LOAD = 1'b0;
        checks++; if (Q !== 4'd0 || state !== 2'd2 || underflow !== 1'b0) begin errors++; $display("FAIL prio_load0 got q=%0d st=%0d uf=%b exp 0 2 0", Q, state, underflow); end
        step();
        checks++; if (underflow !== 1'b0 || sticky_uf !== 1'b0 || state !== 2'd2) begin errors++; $display("FAIL prio_load0_hold got uf=%b sticky=%b st=%0d exp 0 0 2", underflow, sticky_uf, state); end
    endtask

    task automatic test_async_reset();
        DLOAD = 4'd1; PERIODIC = 1'b1; EN = 1'b1; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        step();
        step();
        checks++; if (Q !== 4'd1 || underflow !== 1'b1 || sticky_uf !== 1'b1) begin errors++; $display("FAIL areset_setup got q=%0d uf=%b sticky=%b exp 1 1 1", Q, underflow, sticky_uf); end
        #2 CLR = 1'b1;
        #1;
        checks++; if (Q !== 4'd5 || notQ !== 4'hA || state !== 2'd0) begin errors++; $display("FAIL areset_q got q=%0d notq=%h st=%0d exp 5 a 0", Q, notQ, state); end
        checks++; if ({underflow, sticky_uf} !== 2'b00) begin errors++; $display("FAIL areset_flags got %b exp 00", {underflow, sticky_uf}); end
        step();
        CLR = 1'b0;
        step();
        checks++; if (Q !== 4'd5 || state !== 2'd0 || underflow !== 1'b0) begin errors++; $display("FAIL areset_no_resume got q=%0d st=%0d uf=%b exp 5 0 0", Q, state, underflow); end
    endtask

    task automatic test_wrap_race();
        DLOAD = 4'd15; PERIODIC = 1'b1; EN = 1'b1; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        checks++; if (Q !== 4'd15) begin errors++; $display("FAIL wrap_load got %0d exp 15", Q); end
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++; if (Q !== 4'(15 - k) || underflow !== 1'b0)
                begin errors++; $display("FAIL wrap_count[%0d] got q=%0d uf=%b exp q=%0d uf=0", k, Q, underflow, 15 - k); end
        end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL wrap_zero got %b exp 1", zero); end
        ACK = 1'b1;
        step();
        checks++; if (Q !== 4'd15 || underflow !== 1'b1 || sticky_uf !== 1'b1 || state !== 2'd1)
            begin errors++; $display("FAIL wrap_race got q=%0d uf=%b sticky=%b st=%0d exp 15 1 1 1", Q, underflow, sticky_uf, state); end
        step();
        ACK = 1'b0;
        checks++; if (Q !== 4'd14 || underflow !== 1'b0 || sticky_uf !== 1'b0)
            begin errors++; $display("FAIL wrap_after got q=%0d uf=%b sticky=%b exp 14 0 0", Q, underflow, sticky_uf); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_en_gaps();
        test_priority();
        test_async_reset();
        test_wrap_race();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
